// File: rtl/execute_cycle_pkg.sv
// Shared definitions for the execute stage: widths, ALU opcodes, forward selects,
// the EX/MEM register layout and the forward-mux helper.
package execute_cycle_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              result_src;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   write_data;
    logic [XLEN-1:0]   pc_plus4;
  } exmem_t;

  // Select 2'b11 falls back to the register-file value.
  function automatic logic [XLEN-1:0] fwd_sel(logic [1:0] sel, logic [XLEN-1:0] rf,
                                              logic [XLEN-1:0] wb, logic [XLEN-1:0] mem);
    case (sel)
      FWD_WB:  return wb;
      FWD_MEM: return mem;
      default: return rf;
    endcase
  endfunction

endpackage

// File: rtl/execute_cycle_if.sv
// Bundle between decode/hazard unit (master) and the execute stage (slave).
interface execute_cycle_if;
  import execute_cycle_pkg::*;

  // ID/EX register contents
  logic              RegWriteE;
  logic              ALUSrcE;
  logic              MemWriteE;
  logic              ResultSrcE;
  logic              BranchE;
  logic [2:0]        ALUControlE;
  logic [XLEN-1:0]   RD1_E;
  logic [XLEN-1:0]   RD2_E;
  logic [XLEN-1:0]   Imm_Ext_E;
  logic [REG_AW-1:0] RD_E;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  // Hazard unit / write-back
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic [XLEN-1:0]   ResultW;
  logic              FlushM;
  // Branch redirect
  logic              PCSrcE;
  logic [XLEN-1:0]   PCTargetE;
  // EX/MEM register
  logic              RegWriteM;
  logic              MemWriteM;
  logic              ResultSrcM;
  logic [REG_AW-1:0] RD_M;
  logic [XLEN-1:0]   ALUResultM;
  logic [XLEN-1:0]   WriteDataM;
  logic [XLEN-1:0]   PCPlus4M;

  modport master (
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
           ForwardAE, ForwardBE, ResultW, FlushM,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
           ForwardAE, ForwardBE, ResultW, FlushM,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );

endinterface

// File: rtl/execute_cycle_alu.sv
// Combinational ALU: add/sub/and/or/slt, unused opcodes yield zero.
module execute_cycle_alu
  import execute_cycle_pkg::*;
(
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic [2:0]      alu_ctrl_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  // Operation decode; add/sub wrap, slt is signed and zero-extended.
  always_comb begin
    result_o = '0;
    case (alu_ctrl_i)
      ALU_ADD: result_o = src_a_i + src_b_i;
      ALU_SUB: result_o = src_a_i - src_b_i;
      ALU_AND: result_o = src_a_i & src_b_i;
      ALU_OR:  result_o = src_a_i | src_b_i;
      ALU_SLT: result_o = {{(XLEN-1){1'b0}}, ($signed(src_a_i) < $signed(src_b_i))};
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq resolution, branch target and EX/MEM register.
module execute_cycle
  import execute_cycle_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  execute_cycle_if.slave bus
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] rd2_fwd;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  exmem_t          exmem_d;
  exmem_t          exmem_q;

  // Operand selection; the MEM-stage source is our own registered result, so no comb loop.
  always_comb begin
    src_a   = fwd_sel(bus.ForwardAE, bus.RD1_E, bus.ResultW, exmem_q.alu_result);
    rd2_fwd = fwd_sel(bus.ForwardBE, bus.RD2_E, bus.ResultW, exmem_q.alu_result);
    src_b   = bus.ALUSrcE ? bus.Imm_Ext_E : rd2_fwd;
  end

  execute_cycle_alu u_alu (
    .src_a_i    (src_a),
    .src_b_i    (src_b),
    .alu_ctrl_i (bus.ALUControlE),
    .result_o   (alu_result),
    .zero_o     (alu_zero)
  );

  assign bus.PCSrcE    = bus.BranchE & alu_zero;
  assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

  // Next EX/MEM contents; a flush kills only the side-effecting controls and destination.
  always_comb begin
    exmem_d.reg_write  = bus.RegWriteE;
    exmem_d.mem_write  = bus.MemWriteE;
    exmem_d.result_src = bus.ResultSrcE;
    exmem_d.rd         = bus.RD_E;
    exmem_d.alu_result = alu_result;
    exmem_d.write_data = rd2_fwd;
    exmem_d.pc_plus4   = bus.PCPlus4E;
    if (bus.FlushM) begin
      exmem_d.reg_write  = 1'b0;
      exmem_d.mem_write  = 1'b0;
      exmem_d.result_src = 1'b0;
      exmem_d.rd         = '0;
    end
  end

  // EX/MEM register, loads every edge; reset wins over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign bus.RegWriteM  = exmem_q.reg_write;
  assign bus.MemWriteM  = exmem_q.mem_write;
  assign bus.ResultSrcM = exmem_q.result_src;
  assign bus.RD_M       = exmem_q.rd;
  assign bus.ALUResultM = exmem_q.alu_result;
  assign bus.WriteDataM = exmem_q.write_data;
  assign bus.PCPlus4M   = exmem_q.pc_plus4;

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed vectors with literal expectations plus a
// per-cycle comparison against an arithmetic model of the stage.
module tb_execute_cycle;
  import execute_cycle_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_cycle_if bus ();

  execute_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the EX/MEM register contents
  logic        m_valid = 1'b0;
  logic        m_rw, m_mw, m_rs;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_wd, m_pc4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(logic [1:0] s, logic [31:0] rf, logic [31:0] w,
                                       logic [31:0] m);
    if (s == 2'b01) return w;
    if (s == 2'b10) return m;
    return rf;
  endfunction

  // Signed less-than by sign inspection rather than a signed compare.
  function automatic logic [31:0] model_alu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a + ~b + 32'd1;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd5: begin
        if (a[31] != b[31]) return {31'd0, a[31]};
        return (a < b) ? 32'd1 : 32'd0;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd_now();
    return pick(bus.ForwardBE, bus.RD2_E, bus.ResultW, m_alu);
  endfunction

  function automatic logic [31:0] exp_alu_now();
    logic [31:0] a, b;
    a = pick(bus.ForwardAE, bus.RD1_E, bus.ResultW, m_alu);
    b = bus.ALUSrcE ? bus.Imm_Ext_E : exp_wd_now();
    return model_alu(bus.ALUControlE, a, b);
  endfunction

  // Model update at each edge
  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_rw <= 1'b0; m_mw <= 1'b0; m_rs <= 1'b0; m_rd <= '0;
      m_alu <= '0; m_wd <= '0; m_pc4 <= '0;
    end else begin
      m_rw  <= bus.FlushM ? 1'b0 : bus.RegWriteE;
      m_mw  <= bus.FlushM ? 1'b0 : bus.MemWriteE;
      m_rs  <= bus.FlushM ? 1'b0 : bus.ResultSrcE;
      m_rd  <= bus.FlushM ? 5'd0 : bus.RD_E;
      m_alu <= exp_alu_now();
      m_wd  <= exp_wd_now();
      m_pc4 <= bus.PCPlus4E;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("PCSrcE",     {31'd0, bus.PCSrcE},
          {31'd0, bus.BranchE && (exp_alu_now() == 32'd0)});
      chk("PCTargetE",  bus.PCTargetE, bus.PCE + bus.Imm_Ext_E);
      chk("RegWriteM",  {31'd0, bus.RegWriteM}, {31'd0, m_rw});
      chk("MemWriteM",  {31'd0, bus.MemWriteM}, {31'd0, m_mw});
      chk("ResultSrcM", {31'd0, bus.ResultSrcM}, {31'd0, m_rs});
      chk("RD_M",       {27'd0, bus.RD_M}, {27'd0, m_rd});
      chk("ALUResultM", bus.ALUResultM, m_alu);
      chk("WriteDataM", bus.WriteDataM, m_wd);
      chk("PCPlus4M",   bus.PCPlus4M, m_pc4);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    bus.RegWriteE   = 1'($urandom);
    bus.ALUSrcE     = 1'($urandom);
    bus.MemWriteE   = 1'($urandom);
    bus.ResultSrcE  = 1'($urandom);
    bus.BranchE     = 1'($urandom);
    bus.ALUControlE = 3'($urandom);
    bus.RD1_E       = ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom;
    bus.RD2_E       = ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom;
    bus.Imm_Ext_E   = $urandom;
    bus.RD_E        = 5'($urandom);
    bus.PCE         = $urandom;
    bus.PCPlus4E    = bus.PCE + 32'd4;
    bus.ForwardAE   = 2'($urandom);
    bus.ForwardBE   = 2'($urandom);
    bus.ResultW     = $urandom;
    bus.FlushM      = ($urandom_range(0, 7) == 0);
  endtask

  task automatic quiet_inputs();
    bus.RegWriteE = 0; bus.ALUSrcE = 0; bus.MemWriteE = 0; bus.ResultSrcE = 0;
    bus.BranchE = 0; bus.ALUControlE = ALU_ADD; bus.RD1_E = 0; bus.RD2_E = 0;
    bus.Imm_Ext_E = 0; bus.RD_E = 0; bus.PCE = 0; bus.PCPlus4E = 0;
    bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ResultW = 0; bus.FlushM = 0;
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    rand_inputs();
    step();
    chk("rst RegWriteM",  {31'd0, bus.RegWriteM}, 32'd0);
    chk("rst MemWriteM",  {31'd0, bus.MemWriteM}, 32'd0);
    chk("rst ALUResultM", bus.ALUResultM, 32'd0);
    chk("rst WriteDataM", bus.WriteDataM, 32'd0);
    chk("rst PCPlus4M",   bus.PCPlus4M, 32'd0);
    rst = 1'b0;
    quiet_inputs();

    // ALU operations on -1 and 1
    bus.RD1_E = 32'hFFFF_FFFF; bus.RD2_E = 32'd1;
    bus.ALUControlE = ALU_ADD; step(); chk("add",  bus.ALUResultM, 32'd0);
    bus.ALUControlE = ALU_SUB; step(); chk("sub",  bus.ALUResultM, 32'hFFFF_FFFE);
    bus.ALUControlE = ALU_SLT; step(); chk("slt",  bus.ALUResultM, 32'd1);
    bus.ALUControlE = ALU_AND; step(); chk("and",  bus.ALUResultM, 32'd1);
    bus.ALUControlE = ALU_OR;  step(); chk("or",   bus.ALUResultM, 32'hFFFF_FFFF);
    bus.ALUControlE = 3'b110;  step(); chk("op110", bus.ALUResultM, 32'd0);

    // Forwarding selects for SrcA
    bus.ALUControlE = ALU_ADD; bus.RD1_E = 32'h10; bus.RD2_E = 32'd0;
    step(); chk("fwd setup", bus.ALUResultM, 32'h10);
    bus.RD1_E = 32'd5; bus.ResultW = 32'h20;
    bus.ForwardAE = 2'b10; step(); chk("fwdA 10", bus.ALUResultM, 32'h10);
    bus.ForwardAE = 2'b01; step(); chk("fwdA 01", bus.ALUResultM, 32'h20);
    bus.ForwardAE = 2'b00; step(); chk("fwdA 00", bus.ALUResultM, 32'd5);
    bus.ForwardAE = 2'b11; step(); chk("fwdA 11", bus.ALUResultM, 32'd5);
    // Back-to-back dependency through the EX/MEM register
    bus.ForwardAE = 2'b10; bus.RD2_E = 32'd1;
    step(); chk("b2b 1", bus.ALUResultM, 32'd6);
    step(); chk("b2b 2", bus.ALUResultM, 32'd7);

    // beq taken / not taken, combinational
    bus.ForwardAE = 2'b00; bus.ALUControlE = ALU_SUB; bus.BranchE = 1'b1;
    bus.PCE = 32'h100; bus.Imm_Ext_E = 32'hFFFF_FFF8; bus.RD1_E = 32'd7; bus.RD2_E = 32'd7;
    #1;
    chk("beq taken",  {31'd0, bus.PCSrcE}, 32'd1);
    chk("beq target", bus.PCTargetE, 32'h0000_00F8);
    bus.RD2_E = 32'd8;
    #1;
    chk("beq not taken", {31'd0, bus.PCSrcE}, 32'd0);
    step();
    bus.BranchE = 1'b0;

    // Store with immediate offset and forwarded store data
    bus.ALUControlE = ALU_ADD; bus.ALUSrcE = 1'b1; bus.Imm_Ext_E = 32'd4;
    bus.ForwardBE = 2'b01; bus.ResultW = 32'hAB; bus.RD1_E = 32'h1000; bus.RD2_E = 32'h55;
    bus.MemWriteE = 1'b1;
    step();
    chk("store data", bus.WriteDataM, 32'hAB);
    chk("store addr", bus.ALUResultM, 32'h1004);
    chk("store mw",   {31'd0, bus.MemWriteM}, 32'd1);

    // Flush turns the instruction into a bubble
    bus.ALUSrcE = 1'b0; bus.ForwardBE = 2'b00;
    bus.RegWriteE = 1'b1; bus.MemWriteE = 1'b1; bus.ResultSrcE = 1'b1; bus.RD_E = 5'd9;
    bus.PCPlus4E = 32'h104; bus.FlushM = 1'b1;
    step();
    chk("flush RegWriteM",  {31'd0, bus.RegWriteM}, 32'd0);
    chk("flush MemWriteM",  {31'd0, bus.MemWriteM}, 32'd0);
    chk("flush ResultSrcM", {31'd0, bus.ResultSrcM}, 32'd0);
    chk("flush RD_M",       {27'd0, bus.RD_M}, 32'd0);
    bus.FlushM = 1'b0;
    step();
    chk("noflush RegWriteM", {31'd0, bus.RegWriteM}, 32'd1);
    chk("noflush RD_M",      {27'd0, bus.RD_M}, 32'd9);
    // Reset and flush together
    rst = 1'b1; bus.FlushM = 1'b1;
    step();
    chk("rst+flush RegWriteM", {31'd0, bus.RegWriteM}, 32'd0);
    chk("rst+flush ALUResultM", bus.ALUResultM, 32'd0);
    chk("rst+flush PCPlus4M",  bus.PCPlus4M, 32'd0);
    rst = 1'b0; bus.FlushM = 1'b0;

    // x0 destination passes through untouched
    bus.RegWriteE = 1'b1; bus.MemWriteE = 1'b0; bus.RD_E = 5'd0;
    step();
    chk("x0 RegWriteM", {31'd0, bus.RegWriteM}, 32'd1);
    chk("x0 PCPlus4M",  bus.PCPlus4M, 32'h104);

    // Random traffic checked by the model each cycle
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 24) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
